// File: rtl/fft_result_reader.sv
// rtl/fft_result_reader.sv - Avalon-MM read responder that drains the FFT result buffer to the host.
module fft_result_reader #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 9,
    parameter int NUM_SAMPLES = 256,
    parameter int RAM_LAT     = 2
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              fft_done,
    input  logic              rEn,
    input  logic [63:0]       address,
    output logic              waitRequest,
    output logic [DATA_W-1:0] readData,
    output logic              readDataValid,
    output logic [ADDR_W-1:0] rAddress,
    output logic              sReadEn,
    input  logic [DATA_W-1:0] bufData,
    output logic              results_ready,
    output logic              read_done
);

    localparam int LAT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RAM_LAT - 1);
    localparam logic [ADDR_W-1:0] CNT_FULL  = ADDR_W'(NUM_SAMPLES);
    localparam logic [ADDR_W:0]   ADDR_LIM  = (ADDR_W + 1)'(NUM_SAMPLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READY,
        S_ISSUE,
        S_WAITDATA,
        S_RESPOND,
        S_DONE
    } state_t;

    state_t            state, state_d;
    logic              armed, armed_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              counted_q, counted_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [LAT_W-1:0]  lat_cnt, lat_d;
    logic [ADDR_W-1:0] rd_cnt, rd_d;
    logic [ADDR_W-1:0] rd_inc;
    logic              in_range;

    assign rd_inc   = rd_cnt + 1'b1;
    // Extra top bit keeps the compare correct when NUM_SAMPLES == 2**ADDR_W.
    assign in_range = {1'b0, address[ADDR_W-1:0]} < ADDR_LIM;

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state     <= S_IDLE;
            armed     <= 1'b0;
            addr_q    <= '0;
            counted_q <= 1'b0;
            data_q    <= '0;
            lat_cnt   <= '0;
            rd_cnt    <= '0;
        end else begin
            state     <= state_d;
            armed     <= armed_d;
            addr_q    <= addr_d;
            counted_q <= counted_d;
            data_q    <= data_d;
            lat_cnt   <= lat_d;
            rd_cnt    <= rd_d;
        end
    end

    always_comb begin
        state_d   = state;
        armed_d   = armed;
        addr_d    = addr_q;
        counted_d = counted_q;
        data_d    = data_q;
        lat_d     = lat_cnt;
        rd_d      = rd_cnt;
        case (state)
            S_IDLE: begin
                // A completion pulse wins over a same-cycle read; the read is served from READY.
                if (fft_done) begin
                    armed_d = 1'b1;
                    state_d = S_READY;
                end else if (rEn) begin
                    data_d    = '0;
                    counted_d = 1'b0;
                    state_d   = S_RESPOND;
                end
            end
            S_READY: begin
                if (rEn) begin
                    addr_d = address[ADDR_W-1:0];
                    if (in_range) begin
                        counted_d = 1'b1;
                        state_d   = S_ISSUE;
                    end else begin
                        data_d    = '0;
                        counted_d = 1'b0;
                        state_d   = S_RESPOND;
                    end
                end
            end
            S_ISSUE: begin
                lat_d   = '0;
                state_d = S_WAITDATA;
            end
            S_WAITDATA: begin
                if (lat_cnt == LAT_LAST) begin
                    data_d  = bufData;
                    state_d = S_RESPOND;
                end else begin
                    lat_d = lat_cnt + 1'b1;
                end
            end
            S_RESPOND: begin
                if (counted_q) begin
                    rd_d = rd_inc;
                end
                if (counted_q && (rd_inc == CNT_FULL)) begin
                    state_d = S_DONE;
                end else if (armed) begin
                    state_d = S_READY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                armed_d = 1'b0;
                rd_d    = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        waitRequest   = 1'b1;
        sReadEn       = 1'b0;
        rAddress      = '0;
        readDataValid = 1'b0;
        readData      = '0;
        read_done     = 1'b0;
        results_ready = 1'b0;
        if (!n_rst) begin
            results_ready = armed;
            case (state)
                S_IDLE:  waitRequest = fft_done;
                S_READY: waitRequest = 1'b0;
                S_ISSUE: begin
                    sReadEn  = 1'b1;
                    rAddress = addr_q;
                end
                S_RESPOND: begin
                    readDataValid = 1'b1;
                    readData      = data_q;
                end
                S_DONE:  read_done = 1'b1;
                default: waitRequest = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_result_reader.sv
// tb/tb_fft_result_reader.sv - scoreboard bench for fft_result_reader.
module tb_fft_result_reader;

    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 9;
    localparam int NUM_SAMPLES = 256;
    localparam int RAM_LAT     = 2;

    logic              clk;
    logic              n_rst;
    logic              fft_done;
    logic              rEn;
    logic [63:0]       address;
    logic              waitRequest;
    logic [DATA_W-1:0] readData;
    logic              readDataValid;
    logic [ADDR_W-1:0] rAddress;
    logic              sReadEn;
    logic [DATA_W-1:0] bufData;
    logic              results_ready;
    logic              read_done;

    fft_result_reader #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_SAMPLES(NUM_SAMPLES), .RAM_LAT(RAM_LAT)
    ) dut (
        .clk(clk), .n_rst(n_rst), .fft_done(fft_done), .rEn(rEn), .address(address),
        .waitRequest(waitRequest), .readData(readData), .readDataValid(readDataValid),
        .rAddress(rAddress), .sReadEn(sReadEn), .bufData(bufData),
        .results_ready(results_ready), .read_done(read_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Result buffer: word at addr is 0xA000+addr, valid RAM_LAT cycles after the strobe.
    logic [DATA_W-1:0] pipe [RAM_LAT];
    always @(posedge clk) begin
        pipe[0] <= sReadEn ? (16'hA000 + DATA_W'(rAddress)) : 16'hDEAD;
        for (int p = 1; p < RAM_LAT; p++) pipe[p] <= pipe[p-1];
    end
    assign bufData = pipe[RAM_LAT-1];

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              counted;
    } exp_t;
    exp_t sb[$];

    int mcnt       = 0;
    int done_exp   = 0;
    int done_seen  = 0;

    always @(negedge clk) begin
        if (n_rst) begin
            sb.delete();
            mcnt     = 0;
            done_exp = 0;
        end else begin
            chk("read_done", read_done, done_exp);
            if (read_done) done_seen++;
            done_exp = 0;
            if (readDataValid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("readData", readData, e.data);
                    if (e.counted) begin
                        mcnt++;
                        if (mcnt == NUM_SAMPLES) begin
                            done_exp = 1;
                            mcnt     = 0;
                        end
                    end
                end
            end
        end
    end

    logic armed_m;
    int   issued_cnt;

    task automatic do_read(input logic [63:0] a);
        logic [ADDR_W-1:0] a9;
        logic              exp_cnt;
        logic              accepted;
        exp_t              e;
        int                nsr;
        int                lat;
        a9       = a[ADDR_W-1:0];
        exp_cnt  = armed_m && (a9 < NUM_SAMPLES);
        e.data   = exp_cnt ? (16'hA000 + DATA_W'(a9)) : 16'h0000;
        e.counted = exp_cnt;
        rEn      = 1'b1;
        address  = a;
        accepted = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!waitRequest) begin
                accepted = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!accepted) begin
            chk("accept_timeout", 0, 1);
            @(posedge clk); #1;
            rEn = 1'b0;
            return;
        end
        sb.push_back(e);
        if (exp_cnt) begin
            issued_cnt++;
            if (issued_cnt == NUM_SAMPLES) begin
                armed_m    = 1'b0;
                issued_cnt = 0;
            end
        end
        nsr = 0;
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (k == 1) rEn = 1'b0;
            if (sReadEn) begin
                nsr++;
                chk("rAddress", rAddress, a9);
            end
            if (readDataValid) begin
                lat = k;
                break;
            end
        end
        chk("latency", lat, exp_cnt ? (RAM_LAT + 2) : 1);
        chk("sReadEn_count", nsr, exp_cnt ? 1 : 0);
        @(posedge clk); #1;
    endtask

    task automatic pulse_fft();
        fft_done = 1'b1;
        @(posedge clk); #1;
        fft_done   = 1'b0;
        armed_m    = 1'b1;
        issued_cnt = 0;
    endtask

    task automatic do_reset();
        n_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_rst      = 1'b0;
        armed_m    = 1'b0;
        issued_cnt = 0;
    endtask

    int d0;

    initial begin
        n_rst      = 1'b1;
        fft_done   = 1'b0;
        rEn        = 1'b1;
        address    = 64'd0;
        armed_m    = 1'b0;
        issued_cnt = 0;

        // Reset with rEn held high
        repeat (2) begin
            @(negedge clk);
            chk("rst_waitRequest", waitRequest, 1);
            chk("rst_sReadEn", sReadEn, 0);
            chk("rst_rAddress", rAddress, 0);
            chk("rst_readDataValid", readDataValid, 0);
            chk("rst_readData", readData, 0);
            chk("rst_results_ready", results_ready, 0);
            chk("rst_read_done", read_done, 0);
        end
        @(posedge clk); #1;
        n_rst = 1'b0;
        rEn   = 1'b0;
        @(negedge clk);
        chk("idle_waitRequest", waitRequest, 0);
        @(posedge clk); #1;

        // Read before results
        do_read(64'd5);
        chk("early_results_ready", results_ready, 0);

        // Single read
        pulse_fft();
        chk("armed_results_ready", results_ready, 1);
        do_read(64'h13);

        // Full drain from a clean start
        do_reset();
        pulse_fft();
        d0 = done_seen;
        for (int i = 0; i < NUM_SAMPLES; i++) do_read(64'(i));
        @(posedge clk); #1;
        chk("drain_done_pulses", done_seen - d0, 1);
        chk("drain_results_ready", results_ready, 0);
        do_read(64'h20);

        // fft_done and rEn collide in IDLE
        fft_done = 1'b1;
        rEn      = 1'b1;
        address  = 64'h13;
        @(negedge clk);
        chk("collide_waitRequest", waitRequest, 1);
        chk("collide_valid", readDataValid, 0);
        @(posedge clk); #1;
        fft_done   = 1'b0;
        armed_m    = 1'b1;
        issued_cnt = 0;
        do_read(64'h13);

        // Address decode
        do_read(64'h1FF);
        do_read(64'hFFFF_0000_0000_0010);
        chk("decode_results_ready", results_ready, 1);

        // Reset while waiting for buffer data
        rEn     = 1'b1;
        address = 64'h3;
        @(negedge clk);
        chk("wd_accept", waitRequest, 0);
        @(posedge clk); #1;
        rEn = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(negedge clk);
        chk("wd_rst_waitRequest", waitRequest, 1);
        chk("wd_rst_valid", readDataValid, 0);
        @(posedge clk); #1;
        n_rst      = 1'b0;
        armed_m    = 1'b0;
        issued_cnt = 0;
        repeat (6) @(posedge clk);
        #1;
        chk("wd_results_ready", results_ready, 0);

        // Counting restarts from zero after the new completion
        pulse_fft();
        d0 = done_seen;
        for (int i = 0; i < NUM_SAMPLES; i++) begin
            do_read(64'((i * 37) % NUM_SAMPLES));
            if (i == NUM_SAMPLES - 2) chk("no_early_done", done_seen - d0, 0);
        end
        @(posedge clk); #1;
        chk("restart_done_pulses", done_seen - d0, 1);
        chk("restart_results_ready", results_ready, 0);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_result_reader.md
# fft_result_reader

Avalon-MM read responder that returns the FFT output buffer to the host processor. It is the read-side counterpart to the sample-loading write slave. After the FFT core signals completion, it accepts host reads, fetches words from the result buffer with a fixed latency, and returns them with `readDataValid`. It counts completed in-range reads and, once all results have been drained, pulses `read_done` and disarms.

## Interface
Parameters:
- `DATA_W`, 16, result word width
- `ADDR_W`, 9, result buffer address width
- `NUM_SAMPLES`, 256, results per FFT frame; reads needed to drain
- `RAM_LAT`, 2, result buffer read latency in cycles (≥1)

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge
- `n_rst`  in  1  synchronous reset, active-high (`n_rst=1` resets on the next edge)
- `fft_done`  in  1  FFT core completion pulse; results are valid in the buffer
- `rEn`  in  1  Avalon read request
- `address`  in  64  Avalon word address; only `[ADDR_W-1:0]` is decoded
- `waitRequest`  out  1  Avalon stall; host holds `rEn`/`address` while high
- `readData`  out  DATA_W  response data
- `readDataValid`  out  1  one-cycle response strobe
- `rAddress`  out  ADDR_W  result buffer read address
- `sReadEn`  out  1  result buffer read strobe
- `bufData`  in  DATA_W  buffer data, valid `RAM_LAT` cycles after the `sReadEn` cycle
- `results_ready`  out  1  armed: results available and not yet drained
- `read_done`  out  1  one-cycle pulse after the `NUM_SAMPLES`-th counted response

## Operation
- Registers:
  - state
  - `armed` (drives `results_ready`)
  - `addr_q` (ADDR_W)
  - `counted_q`
  - `data_q` (DATA_W)
  - `lat_cnt`
  - `rd_cnt` (ADDR_W bits, range 0..NUM_SAMPLES)
- **IDLE**:
  - `fft_done=1` sets `armed` and goes to READY; `waitRequest=1` in this cycle and `rEn` is not accepted. `fft_done` has priority.
  - Otherwise, `rEn=1` is accepted (`waitRequest=0`): `data_q<=0`, `counted_q<=0`, go to RESPOND.
- **READY**:
  - `waitRequest=0`.
  - On `rEn`, latch `address[ADDR_W-1:0]` into `addr_q`.
  - If in range (`< NUM_SAMPLES`): `counted_q<=1`, go to ISSUE.
  - Else: `data_q<=0`, `counted_q<=0`, go to RESPOND.
- **ISSUE**: `sReadEn=1`, `rAddress=addr_q`; clear `lat_cnt`; go to WAITDATA.
- **WAITDATA**:
  - Stay `RAM_LAT` cycles.
  - On the last cycle, `data_q<=bufData`, then go to RESPOND.
- **RESPOND**:
  - `readDataValid=1`, `readData=data_q`.
  - If `counted_q`, increment `rd_cnt`.
  - If the incremented value equals `NUM_SAMPLES`, go to DONE.
  - Otherwise return to READY if `armed`, else IDLE.
- **DONE**: `read_done=1`; clear `armed` and `rd_cnt`; go to IDLE.
- `waitRequest` is 1 in ISSUE, WAITDATA, RESPOND, DONE and during reset cycles.
- `rd_cnt` counts responses, not distinct addresses; re-reading an address counts again.
- `address[63:ADDR_W]` is ignored.
- `fft_done` is ignored outside IDLE.
- Outside ISSUE: `rAddress=0`, `sReadEn=0`.
- Outside RESPOND: `readDataValid=0`, `readData=0`.
- Outside DONE: `read_done=0`.

## Timing
- Reset (synchronous):
  - state = IDLE
  - `armed`, `rd_cnt`, `data_q`, `counted_q`, `addr_q` = 0
  - All outputs 0, except `waitRequest=1` while `n_rst=1`.
- Reset mid-transaction drops the outstanding read: no `readDataValid`, `results_ready=0`. The next `fft_done` restarts counting from 0.
- In-range read accepted in cycle 0:
  - `sReadEn` in cycle 1
  - `readDataValid` in cycle `RAM_LAT+2` (cycle 4 at default)
  - READY again in cycle `RAM_LAT+3`
- Zero-data response (IDLE or out-of-range) accepted in cycle 0: `readDataValid` in cycle 1, READY/IDLE in cycle 2.
- `read_done`: cycle immediately after the final counted `readDataValid`; IDLE the cycle after that.
- Maximum one outstanding read; no pipelining.

## Test plan
- **Reset**: hold `n_rst=1` for 2 cycles with `rEn=1` → `waitRequest=1`, all other outputs 0. After release with `fft_done=0` → `waitRequest=0`.
- **Read before results**: IDLE, `rEn=1`, `address=5` → `readDataValid` in cycle 1 with `readData=0x0000`; `sReadEn` never high; `results_ready=0`.
- **Single read**: pulse `fft_done`; buffer model returns `0xA000+addr`; read `address=0x13` → `sReadEn`/`rAddress=0x013` in cycle 1, `readDataValid` with `0xA013` in cycle 4.
- **Full drain**: back-to-back reads of addresses 0..255 honouring `waitRequest` → 256 correct responses. `read_done` fires for one cycle right after the 256th response and `results_ready` falls. A following read returns `0x0000`.
- **Address decode**: armed, read `address=0x1FF` → `0x0000` in cycle 1, no `sReadEn`, `rd_cnt` unchanged. Read `address=0xFFFF_0000_0000_0010` → buffer address `0x010`; the read is counted.
- **Collision and reset**:
  - In IDLE, `fft_done=1` and `rEn=1` in the same cycle → `waitRequest=1`, no response that cycle; the read is served from READY afterwards.
  - Reset during WAITDATA → no `readDataValid`. After a new `fft_done`, exactly 256 counted reads are needed for `read_done`.
